// File: rtl/decomm_pkg.sv
// Shared constants and types for the 3-lane to 5-port decommutator.
// Contents: lane/port counts, destination field width, lane-index type,
// and a modulo-3 increment helper for the rotating priority pointer.
package decomm_pkg;

   localparam int unsigned NUM_IN  = 3;
   localparam int unsigned NUM_OUT = 5;
   localparam int unsigned DEST_W  = 3;

   typedef logic [1:0] lane_idx_t;

   // (a + k) mod NUM_IN, used both for priority scan order and pointer advance
   function automatic lane_idx_t rr_add(input lane_idx_t a, input int unsigned k);
      int unsigned s;
      s = (32'(a) + k) % NUM_IN;
      return lane_idx_t'(s);
   endfunction

endpackage

// File: rtl/decomm_rr_arbiter.sv
// Rotating-priority arbiter for one output port.
// Ports:
//   req   - per-lane request (already qualified by port writability)
//   rr    - lane with highest priority; order is rr, rr+1, rr+2 mod 3
//   grant - one-hot grant, all zero when no lane requests
module decomm_rr_arbiter
   import decomm_pkg::*;
(
   input  logic [NUM_IN-1:0] req,
   input  lane_idx_t         rr,
   output logic [NUM_IN-1:0] grant
);

   lane_idx_t idx;
   logic      found;

   // Scan lanes starting at rr; first requester wins
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = rr;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         idx = rr_add(rr, k);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/decommutator_3_to_5.sv
// Routes words from 3 input lanes to 5 output ports, each port backed by a
// one-entry holding register. Lanes contending for the same port are resolved
// by a single rotating pointer shared by all ports.
// Optional feature: define DECOMM_PARITY_EN to add in_par (even parity per
// lane); a lane with bad parity is accepted, dropped, and sets err.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   in_valid/in_ready  - per-lane handshake (in_ready is combinational)
//   in_dest            - 3-bit destination per lane, legal 0..4
//   in_data            - W-bit payload per lane
//   in_par             - per-lane parity bit (DECOMM_PARITY_EN only)
//   out_valid/out_ready- per-port handshake, out_valid is the full flag
//   out_data           - W-bit registered payload per port
//   err                - sticky flag: illegal destination (or bad parity)
module decommutator_3_to_5
   import decomm_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic [NUM_IN*DEST_W-1:0] in_dest,
   input  logic [NUM_IN*W-1:0]     in_data,
`ifdef DECOMM_PARITY_EN
   input  logic [NUM_IN-1:0]       in_par,
`endif
   output logic [NUM_OUT-1:0]      out_valid,
   input  logic [NUM_OUT-1:0]      out_ready,
   output logic [NUM_OUT*W-1:0]    out_data,
   output logic                    err
);

   logic [NUM_OUT-1:0] full;
   lane_idx_t          rr;

   logic [DEST_W-1:0]  dest     [NUM_IN];
   logic [NUM_IN-1:0]  legal;
   logic [NUM_IN-1:0]  bad;
   logic [NUM_OUT-1:0] writable;
   logic [NUM_IN-1:0]  req      [NUM_OUT];
   logic [NUM_IN-1:0]  grant    [NUM_OUT];
   logic [NUM_OUT-1:0] wr;
   logic [W-1:0]       wr_data  [NUM_OUT];
   logic               contend;
   logic               err_set;

   assign out_valid = full;

   // Lane decode, parity qualification and per-port request vectors
   always_comb begin
      legal    = '0;
      bad      = '0;
      writable = ~full | out_ready;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         dest[i]  = in_dest[i*DEST_W +: DEST_W];
         legal[i] = (dest[i] < DEST_W'(NUM_OUT));
`ifdef DECOMM_PARITY_EN
         bad[i]   = ^{in_par[i], in_data[i*W +: W]};
`endif
      end
      for (int unsigned j = 0; j < NUM_OUT; j++) begin
         req[j] = '0;
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            req[j][i] = !rst && in_valid[i] && legal[i] && !bad[i] &&
                        (dest[i] == DEST_W'(j)) && writable[j];
         end
      end
   end

   for (genvar j = 0; j < NUM_OUT; j++) begin : g_arb
      decomm_rr_arbiter u_arb (
         .req   (req[j]),
         .rr    (rr),
         .grant (grant[j])
      );
   end

   // Handshake back to lanes, write selection and contention detection.
   // Illegal-destination and bad-parity words are accepted and discarded.
   always_comb begin
      in_ready = '0;
      wr       = '0;
      contend  = 1'b0;
      err_set  = 1'b0;
      for (int unsigned j = 0; j < NUM_OUT; j++) begin
         wr_data[j] = '0;
         wr[j]      = |grant[j];
         contend    = contend | (|(req[j] & ~grant[j]));
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant[j][i]) wr_data[j] = in_data[i*W +: W];
         end
      end
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (!rst && in_valid[i]) begin
            if (!legal[i] || bad[i]) begin
               in_ready[i] = 1'b1;
               err_set     = 1'b1;
            end else begin
               for (int unsigned j = 0; j < NUM_OUT; j++) begin
                  if (grant[j][i]) in_ready[i] = 1'b1;
               end
            end
         end
      end
   end

   // Holding registers, rotating pointer and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         full     <= '0;
         out_data <= '0;
         rr       <= '0;
         err      <= 1'b0;
      end else begin
         for (int unsigned j = 0; j < NUM_OUT; j++) begin
            if (wr[j]) begin
               full[j]            <= 1'b1;
               out_data[j*W +: W] <= wr_data[j];
            end else if (out_ready[j]) begin
               full[j] <= 1'b0;
            end
         end
         if (contend) rr <= rr_add(rr, 1);
         if (err_set) err <= 1'b1;
      end
   end

endmodule

// File: doc/decommutator_3_to_5.md
DECOMMUTATOR_3_TO_5 -- requirements
Module: decommutator_3_to_5

Interface
REQ-001 SHALL have parameter W, default 8, data width per lane.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  3  lane i presents a word.
REQ-005 SHALL have port in_ready  output  3  lane i word accepted this cycle.
REQ-006 SHALL have port in_dest  input  9  lane i destination in bits [3i+2:3i], legal values 0..4.
REQ-007 SHALL have port in_data  input  3*W  lane i payload in bits [W*i+W-1:W*i].
REQ-008 SHALL have port out_valid  output  5  output port j holds a word.
REQ-009 SHALL have port out_ready  input  5  consumer of port j takes the word.
REQ-010 SHALL have port out_data  output  5*W  port j payload in bits [W*j+W-1:W*j].
REQ-011 SHALL have port err  output  1  sticky illegal-destination flag.

Function
REQ-012 SHALL give each output port a one-entry holding register with a full flag, driving out_valid[j] directly from the full flag.
REQ-013 SHALL make port j writable in a cycle when it is empty, or full with out_ready[j]=1 (drain and refill in the same cycle).
REQ-014 SHALL set in_ready[i]=1 only when in_valid[i]=1, in_dest[i] is legal, port in_dest[i] is writable, and lane i wins arbitration for that port.
REQ-015 SHALL arbitrate contending lanes with one global rotating pointer rr in 0..2; priority order is rr, rr+1, rr+2 mod 3.
REQ-016 SHALL advance rr by 1 mod 3 at the end of any cycle in which at least one lane was refused because another lane won the same port; otherwise rr SHALL hold.
REQ-017 SHALL present a word accepted at edge N on out_data[j] with out_valid[j]=1 from edge N onward, giving 1-cycle latency and sustaining 1 word/cycle per port.
REQ-018 SHALL clear full[j] on out_ready[j]=1 with no concurrent write, and SHALL hold out_data[j] stable while out_valid[j]=1 and out_ready[j]=0.
REQ-019 SHALL route lanes targeting different ports in parallel; up to 3 writes per cycle.
REQ-020 SHALL accept and discard a valid word with in_dest 5..7 (in_ready[i]=1, no port written) and set err=1 at that edge.
REQ-021 SHALL ignore out_ready[j] when out_valid[j]=0.

Reset
REQ-022 SHALL, while rst=1 at an edge, clear all full flags, out_data to 0, rr to 0, and err to 0.
REQ-023 SHALL force in_ready=0 during any cycle with rst=1; words presented then are neither accepted nor lost silently (the producer retries).
REQ-024 SHALL discard buffered words on reset mid-operation; no partial state survives.

Configuration
REQ-025 SHALL support macro DECOMM_PARITY_EN: when defined, add input in_par (3 bits, even parity over lane payload); a lane with bad parity is accepted, dropped, and sets err.
REQ-026 SHALL, without DECOMM_PARITY_EN, omit in_par, perform no parity check, and set err only per REQ-020.

Structure
REQ-027 SHALL place NUM_IN=3, NUM_OUT=5, DEST_W=3 and the lane-index typedef in shared package decomm_pkg.
REQ-028 SHALL implement arbitration in one sub-module decomm_rr_arbiter (3 requests, rr input, one-hot grant), instantiated once per output port.

Verification
REQ-029 SHALL check: after reset, lane0 dest=2 data=0xA5 one cycle, out_ready=all 1 -> out_valid[2]=1, out_data[2]=0xA5 next cycle, then 0.
REQ-030 SHALL check: lanes 0,1,2 all dest=4 (0x11,0x22,0x33), out_ready[4]=1 held -> port 4 emits 0x11, 0x22, 0x33 on consecutive cycles, with rr stepping 0->1->2.
REQ-031 SHALL check: port 3 full, out_ready[3]=0, lane1 dest=3 -> in_ready[1]=0 and out_data[3] unchanged; raise out_ready[3] -> lane1 accepted the same cycle.
REQ-032 SHALL check: lane2 dest=6 -> in_ready[2]=1, no out_valid change, err=1 and stays 1 until rst.
REQ-033 SHALL check: ports 0,1 full, then rst=1 one cycle -> out_valid=0, err=0, rr=0, in_ready=0 during reset.
REQ-034 SHALL check, with DECOMM_PARITY_EN: lane0 data=0x01, in_par[0]=0 -> word dropped and err=1; with in_par[0]=1 -> delivered.
